// File: rtl/controller.sv
// controller: host-side test-harness controller. Owns the program memory,
// drives the core clock/reset, serves the core's Wishbone instruction port and
// runs a UART byte-command interface (W/R/I/S/H) for the host.
// Optional feature macro: SECOND_MEMORY_EN adds the data_mem_* Wishbone port
// and a separate data memory, selected from the UART side by address bit 31.
module controller #(
    parameter int          CLK_FREQ           = 100000000,
    parameter int          BIT_RATE           = 115200,
    parameter int          PAYLOAD_BITS       = 8,
    parameter int          BUFFER_SIZE        = 8,
    parameter int          PULSE_CONTROL_BITS = 32,
    parameter int          BUS_WIDTH          = 32,
    parameter int          WORD_SIZE_BY       = 4,
    parameter logic [31:0] ID                 = 32'h0000_0001,
    parameter int          RESET_CLK_CYCLES   = 20,
    parameter              MEMORY_FILE        = "",
    parameter int          MEMORY_SIZE        = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 sck_i,
    input  logic                 cs_i,
    input  logic                 mosi_i,
    input  logic                 rw_i,
    output logic                 miso_o,
    output logic                 intr_o,
    output logic                 clk_core_o,
    output logic                 rst_core_o,
    input  logic                 core_cyc_i,
    input  logic                 core_stb_i,
    input  logic                 core_we_i,
    input  logic [BUS_WIDTH-1:0] core_addr_i,
    input  logic [BUS_WIDTH-1:0] core_data_i,
    output logic [BUS_WIDTH-1:0] core_data_o,
    output logic                 core_ack_o
`ifdef SECOND_MEMORY_EN
    ,
    input  logic                 data_mem_cyc_i,
    input  logic                 data_mem_stb_i,
    input  logic                 data_mem_we_i,
    input  logic [BUS_WIDTH-1:0] data_mem_addr_i,
    input  logic [BUS_WIDTH-1:0] data_mem_data_i,
    output logic [BUS_WIDTH-1:0] data_mem_data_o,
    output logic                 data_mem_ack_o
`endif
);
    localparam int BIT_CYCLES = CLK_FREQ / BIT_RATE;
    localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
    localparam int BIT_IDX_W  = $clog2(PAYLOAD_BITS + 2);
    localparam int MEM_AW     = $clog2(MEMORY_SIZE);
    localparam int OFF_W      = $clog2(WORD_SIZE_BY);
    localparam int DEPTH      = MEMORY_SIZE / WORD_SIZE_BY;
    localparam int PTR_W      = $clog2(BUFFER_SIZE);
    localparam int FCNT_W     = $clog2(BUFFER_SIZE + 1);
    localparam int LEFT_W     = $clog2(WORD_SIZE_BY + 1);
    localparam logic [BIT_IDX_W-1:0] LAST_DATA  = BIT_IDX_W'(PAYLOAD_BITS);
    localparam logic [BIT_IDX_W-1:0] FRAME_LAST = BIT_IDX_W'(PAYLOAD_BITS + 1);
    localparam logic [7:0] OP_WRITE = 8'h57, OP_READ = 8'h52, OP_ID = 8'h49;
    localparam logic [7:0] OP_START = 8'h53, OP_HALT = 8'h48;
    localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;

    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, RESPOND} cmd_state_t;

    assign clk_core_o = clk;
    assign miso_o     = 1'b0;
    assign intr_o     = 1'b0;

    // ---------------- memories ----------------
    logic [BUS_WIDTH-1:0] imem [DEPTH];

    logic [31:0]          addr, addr_shift;
    logic [BUS_WIDTH-1:0] wdata, wdata_shift, uart_rd_word;
    logic [7:0]           rx_byte;
    logic                 uart_we, core_access;
    logic [MEM_AW-OFF_W-1:0] rd_idx, wr_idx, core_idx;

    assign addr_shift  = {rx_byte, addr[31:8]};
    assign wdata_shift = {rx_byte, wdata[BUS_WIDTH-1:8]};
    assign rd_idx      = addr_shift[MEM_AW-1:OFF_W];
    assign wr_idx      = addr[MEM_AW-1:OFF_W];
    assign core_idx    = core_addr_i[MEM_AW-1:OFF_W];
    assign core_access = core_cyc_i && core_stb_i && !rst_core_o && !core_ack_o;

    // Instruction memory writes; the UART write comes last so it wins on a shared word.
    // NOTE: memories are deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (core_access && core_we_i) imem[core_idx] <= core_data_i;
`ifdef SECOND_MEMORY_EN
        if (uart_we && !addr[31]) imem[wr_idx] <= wdata_shift;
`else
        if (uart_we) imem[wr_idx] <= wdata_shift;
`endif
    end

    // Instruction port: registered one-cycle ack and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_ack_o  <= 1'b0;
            core_data_o <= '0;
        end else begin
            core_ack_o <= core_access;
            if (core_access && !core_we_i) core_data_o <= imem[core_idx];
        end
    end

`ifdef SECOND_MEMORY_EN
    logic [BUS_WIDTH-1:0] dmem [DEPTH];
    logic [MEM_AW-OFF_W-1:0] data_idx;
    logic data_access;
    assign data_idx    = data_mem_addr_i[MEM_AW-1:OFF_W];
    assign data_access = data_mem_cyc_i && data_mem_stb_i && !rst_core_o && !data_mem_ack_o;
    assign uart_rd_word = addr_shift[31] ? dmem[rd_idx] : imem[rd_idx];

    // Data memory writes, UART last so it wins on a shared word.
    always_ff @(posedge clk) begin
        if (data_access && data_mem_we_i) dmem[data_idx] <= data_mem_data_i;
        if (uart_we && addr[31]) dmem[wr_idx] <= wdata_shift;
    end

    // Data port: same handshake as the instruction port.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_mem_ack_o  <= 1'b0;
            data_mem_data_o <= '0;
        end else begin
            data_mem_ack_o <= data_access;
            if (data_access && !data_mem_we_i) data_mem_data_o <= dmem[data_idx];
        end
    end
`else
    assign uart_rd_word = imem[rd_idx];
`endif

    // ---------------- UART receive ----------------
    logic [1:0]              rx_sync;
    logic                    rx_busy, rx_valid;
    logic [CNT_W-1:0]        rx_cnt;
    logic [BIT_IDX_W-1:0]    rx_bit;
    logic [PAYLOAD_BITS-1:0] rx_shift;
    assign rx_byte = rx_shift[7:0];

    // Receiver: synchronise rx, sample each bit at mid-period, validate start and stop.
    // NOTE: sequential state uses <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_busy  <= 1'b0;
            rx_valid <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (!rx_sync[1]) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CNT_W'(BIT_CYCLES / 2 - 1);
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CNT_W'(BIT_CYCLES - 1);
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == '0) begin
                    if (rx_sync[1]) rx_busy <= 1'b0;   // false start
                end else if (rx_bit <= LAST_DATA) begin
                    rx_shift <= {rx_sync[1], rx_shift[PAYLOAD_BITS-1:1]};
                end else begin
                    rx_busy  <= 1'b0;
                    rx_valid <= rx_sync[1];           // bad stop bit drops the byte
                end
            end
        end
    end

    // ---------------- TX FIFO and transmitter ----------------
    logic [PAYLOAD_BITS-1:0]   fifo_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]         fifo_count;
    logic                      push, push_ok, tx_pop, tx_busy, tx_done;
    logic [7:0]                push_data;
    logic [CNT_W-1:0]          tx_cnt;
    logic [BIT_IDX_W-1:0]      tx_bit;
    logic [PAYLOAD_BITS+1:0]   tx_frame;

    assign push_ok = push && (fifo_count != FCNT_W'(BUFFER_SIZE));
    assign tx_done = tx_busy && (tx_cnt == '0) && (tx_bit == FRAME_LAST);
    assign tx_pop  = (fifo_count != '0) && (!tx_busy || tx_done);
    assign tx      = tx_frame[0];

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= PAYLOAD_BITS'(push_data);
    end

    // FIFO pointers and occupancy; pushes into a full FIFO are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(BUFFER_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= (rd_ptr == PTR_W'(BUFFER_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, tx_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmitter: shifts start/data/stop frames, loading the next byte at the end of a stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_frame <= '1;
        end else if (tx_pop) begin
            tx_busy  <= 1'b1;
            tx_cnt   <= CNT_W'(BIT_CYCLES - 1);
            tx_bit   <= '0;
            tx_frame <= {1'b1, fifo_mem[rd_ptr], 1'b0};
        end else if (tx_busy) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bit == FRAME_LAST) begin
                tx_busy <= 1'b0;
            end else begin
                tx_cnt   <= CNT_W'(BIT_CYCLES - 1);
                tx_bit   <= tx_bit + 1'b1;
                tx_frame <= {1'b1, tx_frame[PAYLOAD_BITS+1:1]};
            end
        end
    end

    // ---------------- command FSM ----------------
    cmd_state_t           state, state_next;
    logic [7:0]           opcode, opcode_next;
    logic [31:0]          addr_next;
    logic [BUS_WIDTH-1:0] wdata_next, reply, reply_next;
    logic [LEFT_W-1:0]    byte_cnt, byte_cnt_next, reply_left, reply_left_next;
    logic                 start_req, halt_req;

    // Command state and field registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opcode     <= '0;
            addr       <= '0;
            wdata      <= '0;
            byte_cnt   <= '0;
            reply      <= '0;
            reply_left <= '0;
        end else begin
            state      <= state_next;
            opcode     <= opcode_next;
            addr       <= addr_next;
            wdata      <= wdata_next;
            byte_cnt   <= byte_cnt_next;
            reply      <= reply_next;
            reply_left <= reply_left_next;
        end
    end

    // Command decode: collect little-endian fields, act, and queue the reply bytes.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_next      = state;
        opcode_next     = opcode;
        addr_next       = addr;
        wdata_next      = wdata;
        byte_cnt_next   = byte_cnt;
        reply_next      = reply;
        reply_left_next = reply_left;
        push            = 1'b0;
        push_data       = reply[7:0];
        uart_we         = 1'b0;
        start_req       = 1'b0;
        halt_req        = 1'b0;
        case (state)
            IDLE: if (rx_valid) begin
                byte_cnt_next = '0;
                case (rx_byte)
                    OP_WRITE, OP_READ: begin
                        opcode_next = rx_byte;
                        state_next  = GET_ADDR;
                    end
                    OP_ID: begin
                        reply_next      = BUS_WIDTH'(ID);
                        reply_left_next = LEFT_W'(4);
                        state_next      = RESPOND;
                    end
                    OP_START, OP_HALT: begin
                        start_req       = (rx_byte == OP_START);
                        halt_req        = (rx_byte == OP_HALT);
                        reply_next      = BUS_WIDTH'(ACK);
                        reply_left_next = LEFT_W'(1);
                        state_next      = RESPOND;
                    end
                    default: begin
                        push      = 1'b1;
                        push_data = NAK;
                    end
                endcase
            end
            GET_ADDR: if (rx_valid) begin
                addr_next     = addr_shift;
                byte_cnt_next = byte_cnt + 1'b1;
                if (byte_cnt == LEFT_W'(3)) begin
                    byte_cnt_next = '0;
                    if (opcode == OP_WRITE) begin
                        state_next = GET_DATA;
                    end else begin
                        reply_next      = uart_rd_word;
                        reply_left_next = LEFT_W'(WORD_SIZE_BY);
                        state_next      = RESPOND;
                    end
                end
            end
            GET_DATA: if (rx_valid) begin
                wdata_next    = wdata_shift;
                byte_cnt_next = byte_cnt + 1'b1;
                if (byte_cnt == LEFT_W'(WORD_SIZE_BY - 1)) begin
                    uart_we         = 1'b1;
                    reply_next      = BUS_WIDTH'(ACK);
                    reply_left_next = LEFT_W'(1);
                    state_next      = RESPOND;
                end
            end
            RESPOND: begin
                push            = 1'b1;
                reply_next      = reply >> 8;
                reply_left_next = reply_left - 1'b1;
                if (reply_left == LEFT_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- core reset control ----------------
    logic [PULSE_CONTROL_BITS-1:0] rst_cnt;

    // Core reset: halt forces it high; start (re)loads a countdown that releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_core_o <= 1'b1;
            rst_cnt    <= '0;
        end else if (halt_req) begin
            rst_core_o <= 1'b1;
            rst_cnt    <= '0;
        end else if (start_req) begin
            rst_core_o <= 1'b1;
            rst_cnt    <= PULSE_CONTROL_BITS'(RESET_CLK_CYCLES);
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
            if (rst_cnt == PULSE_CONTROL_BITS'(1)) rst_core_o <= 1'b0;
        end
    end

    // SPI pins are reserved; address bits outside the memory window are ignored.
    logic unused_bits;
`ifdef SECOND_MEMORY_EN
    assign unused_bits = ^{sck_i, cs_i, mosi_i, rw_i, core_addr_i, addr, addr_shift, data_mem_addr_i};
`else
    assign unused_bits = ^{sck_i, cs_i, mosi_i, rw_i, core_addr_i, addr, addr_shift};
`endif

endmodule

// File: tb/tb_controller.sv
// tb_controller: table-driven UART command vectors plus hand-written Wishbone
// and core-reset sequences for controller. Bit period shortened to 16 cycles.
module tb_controller;
    localparam int CLK_FREQ = 1600000;
    localparam int BIT_RATE = 100000;
    localparam int BIT      = 16;

    logic        clk = 1'b0;
    logic        rst, rx, tx;
    logic        sck_i, cs_i, mosi_i, rw_i, miso_o, intr_o, clk_core_o, rst_core_o;
    logic        core_cyc_i, core_stb_i, core_we_i, core_ack_o;
    logic [31:0] core_addr_i, core_data_i, core_data_o;
`ifdef SECOND_MEMORY_EN
    logic        data_mem_cyc_i, data_mem_stb_i, data_mem_we_i, data_mem_ack_o;
    logic [31:0] data_mem_addr_i, data_mem_data_i, data_mem_data_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    controller #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .sck_i(sck_i), .cs_i(cs_i), .mosi_i(mosi_i), .rw_i(rw_i),
        .miso_o(miso_o), .intr_o(intr_o),
        .clk_core_o(clk_core_o), .rst_core_o(rst_core_o),
        .core_cyc_i(core_cyc_i), .core_stb_i(core_stb_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_data_i(core_data_i),
        .core_data_o(core_data_o), .core_ack_o(core_ack_o)
`ifdef SECOND_MEMORY_EN
        ,
        .data_mem_cyc_i(data_mem_cyc_i), .data_mem_stb_i(data_mem_stb_i),
        .data_mem_we_i(data_mem_we_i), .data_mem_addr_i(data_mem_addr_i),
        .data_mem_data_i(data_mem_data_i), .data_mem_data_o(data_mem_data_o),
        .data_mem_ack_o(data_mem_ack_o)
`endif
    );

    typedef struct {
        int          ncmd;
        logic [71:0] cmd;   // byte i at [8*i +: 8]: {data32, addr32, opcode}
        int          nrsp;
        logic [31:0] rsp;   // expected reply, byte i at [8*i +: 8]
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_cmd(input int n, input logic [71:0] c);
        for (int i = 0; i < n; i++) send_byte(c[8*i +: 8]);
    endtask

    task automatic expect_reply(input string name, input int n, input logic [31:0] exp);
        int waited = 0;
        while (rx_q.size() < n && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (rx_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d bytes expected %0d", name, rx_q.size(), n);
            rx_q.delete();
        end else begin
            for (int i = 0; i < n; i++) check(name, 32'(rx_q.pop_front()), 32'(exp[8*i +: 8]));
        end
    endtask

    task automatic wait_core_running(input string name);
        int waited = 0;
        while (rst_core_o !== 1'b0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check(name, 32'(rst_core_o), 32'd0);
    endtask

    // Serial monitor on tx: decodes 8N1 frames into rx_q.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                check("tx_stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[$];
        logic [71:0] c;
        int width, waited, acks;

        vecs.push_back('{1, 72'h49, 4, 32'h0000_0001});                         // I -> ID
        vecs.push_back('{9, {32'hDEAD_BEEF, 32'h0000_0010, 8'h57}, 1, 32'h06}); // W 0x10
        vecs.push_back('{5, {32'h0, 32'h0000_0010, 8'h52}, 4, 32'hDEAD_BEEF});  // R 0x10
        vecs.push_back('{5, {32'h0, 32'h0000_1010, 8'h52}, 4, 32'hDEAD_BEEF});  // R wraps
        vecs.push_back('{1, 72'h00, 1, 32'h15});                                // unknown
        vecs.push_back('{9, {32'h0BAD_F00D, 32'h0000_0024, 8'h57}, 1, 32'h06}); // W 0x24
        vecs.push_back('{5, {32'h0, 32'h0000_0024, 8'h52}, 4, 32'h0BAD_F00D});  // R 0x24
        vecs.push_back('{1, 72'h58, 1, 32'h15});                                // 'X'
        vecs.push_back('{9, {32'h55AA_33CC, 32'h0000_1024, 8'h57}, 1, 32'h06}); // W wraps
        vecs.push_back('{5, {32'h0, 32'h0000_0024, 8'h52}, 4, 32'h55AA_33CC});
`ifndef SECOND_MEMORY_EN
        vecs.push_back('{5, {32'h0, 32'h8000_0010, 8'h52}, 4, 32'hDEAD_BEEF});  // bit 31 ignored
`endif

        rst = 1'b1; rx = 1'b1;
        sck_i = 1'b0; cs_i = 1'b0; mosi_i = 1'b0; rw_i = 1'b0;
        core_cyc_i = 1'b1; core_stb_i = 1'b1; core_we_i = 1'b0;
        core_addr_i = 32'h10; core_data_i = '0;
`ifdef SECOND_MEMORY_EN
        data_mem_cyc_i = 1'b0; data_mem_stb_i = 1'b0; data_mem_we_i = 1'b0;
        data_mem_addr_i = '0; data_mem_data_i = '0;
`endif

        // Reset state, with a core request already presented.
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rst_core", 32'(rst_core_o), 32'd1);
        check("reset_ack", 32'(core_ack_o), 32'd0);
        check("reset_core_data", core_data_o, 32'd0);
        check("reset_spi_outputs", 32'({miso_o, intr_o}), 32'd0);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (core_ack_o) acks++;
        end
        check("halted_no_ack", 32'(acks), 32'd0);
        core_cyc_i = 1'b0; core_stb_i = 1'b0;

        // UART command vectors.
        for (int v = 0; v < vecs.size(); v++) begin
            c = vecs[v].cmd;
            send_cmd(vecs[v].ncmd, c);
            expect_reply($sformatf("vec%0d", v), vecs[v].nrsp, vecs[v].rsp);
        end

        // Start the core from halt.
        send_byte(8'h53);
        expect_reply("start_reply", 1, 32'h06);
        wait_core_running("start_released");

        // Held core read: ack every second cycle with the stored word.
        core_addr_i = 32'h10; core_cyc_i = 1'b1; core_stb_i = 1'b1; core_we_i = 1'b0;
        @(negedge clk);
        check("core_rd_ack1", 32'(core_ack_o), 32'd1);
        check("core_rd_data", core_data_o, 32'hDEAD_BEEF);
        @(negedge clk);
        check("core_rd_gap", 32'(core_ack_o), 32'd0);
        @(negedge clk);
        check("core_rd_ack2", 32'(core_ack_o), 32'd1);
        core_addr_i = 32'h1024;
        @(negedge clk);
        check("core_rd_gap2", 32'(core_ack_o), 32'd0);
        @(negedge clk);
        check("core_wrap_ack", 32'(core_ack_o), 32'd1);
        check("core_wrap_data", core_data_o, 32'h55AA_33CC);
        core_cyc_i = 1'b0; core_stb_i = 1'b0;
        @(negedge clk);

        // Core write, read back over UART.
        core_addr_i = 32'h30; core_data_i = 32'hCAFE_F00D;
        core_cyc_i = 1'b1; core_stb_i = 1'b1; core_we_i = 1'b1;
        @(negedge clk);
        check("core_wr_ack", 32'(core_ack_o), 32'd1);
        core_cyc_i = 1'b0; core_stb_i = 1'b0; core_we_i = 1'b0;
        send_cmd(5, {32'h0, 32'h0000_0030, 8'h52});
        expect_reply("core_wr_readback", 4, 32'hCAFE_F00D);

        // 'S' while running: reset pulse of exactly RESET_CLK_CYCLES.
        width = 0;
        waited = 0;
        fork
            send_byte(8'h53);
            begin
                while (rst_core_o !== 1'b1 && waited < 400) begin
                    @(negedge clk);
                    waited++;
                end
                while (rst_core_o === 1'b1 && width < 100) begin
                    width++;
                    @(negedge clk);
                end
            end
        join
        check("restart_pulse_width", 32'(width), 32'd20);
        expect_reply("restart_reply", 1, 32'h06);
        wait_core_running("restart_released");

        // 'H' with a pending core request: halted core never acks.
        core_addr_i = 32'h10; core_cyc_i = 1'b1; core_stb_i = 1'b1;
        send_byte(8'h48);
        expect_reply("halt_reply", 1, 32'h06);
        check("halt_rst_core", 32'(rst_core_o), 32'd1);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (core_ack_o) acks++;
        end
        check("halt_no_ack", 32'(acks), 32'd0);
        core_cyc_i = 1'b0; core_stb_i = 1'b0;

`ifdef SECOND_MEMORY_EN
        send_cmd(9, {32'h1111_1111, 32'h0000_0008, 8'h57});
        expect_reply("imem8_write", 1, 32'h06);
        send_byte(8'h53);
        expect_reply("dm_start_reply", 1, 32'h06);
        wait_core_running("dm_released");
        data_mem_addr_i = 32'h8; data_mem_data_i = 32'h1234_5678;
        data_mem_cyc_i = 1'b1; data_mem_stb_i = 1'b1; data_mem_we_i = 1'b1;
        @(negedge clk);
        check("dm_wr_ack", 32'(data_mem_ack_o), 32'd1);
        data_mem_we_i = 1'b0;
        @(negedge clk);
        check("dm_gap", 32'(data_mem_ack_o), 32'd0);
        @(negedge clk);
        check("dm_rd_ack", 32'(data_mem_ack_o), 32'd1);
        check("dm_rd_data", data_mem_data_o, 32'h1234_5678);
        data_mem_cyc_i = 1'b0; data_mem_stb_i = 1'b0;
        send_cmd(5, {32'h0, 32'h8000_0008, 8'h52});
        expect_reply("uart_dm_read", 4, 32'h1234_5678);
        send_cmd(5, {32'h0, 32'h0000_0008, 8'h52});
        expect_reply("imem8_unchanged", 4, 32'h1111_1111);
`endif

        repeat (4 * BIT) @(negedge clk);
        check("no_extra_tx_bytes", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
